// File: rtl/mips_store_buffer_if.sv
// Core-side and memory-side signals of the MIPS posted-write store buffer.
// slave: the buffer itself; master: whoever drives the core requests and memory ack.
interface mips_store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          memwrite;
  logic          memread;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;

  modport slave (
    input  memwrite, memread, dataadr, writedata, mem_ack,
    output stall, fwd_hit, fwd_data, empty, mem_req, mem_addr, mem_wdata
  );

  modport master (
    output memwrite, memread, dataadr, writedata, mem_ack,
    input  stall, fwd_hit, fwd_data, empty, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_store_buffer.sv
// Posted-write FIFO between the multicycle MIPS data port and data memory.
// Define STORE_BUF_FWD_EN to forward buffered store data to loads instead of stalling them.
module mips_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  mips_store_buffer_if.slave  bus
);
  localparam int unsigned     PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;

  logic full;
  logic push;
  logic pop;

  assign full          = (count_q == FULL_CNT);
  assign bus.mem_req   = (count_q != '0);
  assign bus.empty     = (count_q == '0);
  // A full buffer rejects the store outright, even if the head drains this same edge.
  assign push          = bus.memwrite && !full;
  assign pop           = bus.mem_req && bus.mem_ack;
  assign bus.mem_addr  = bus.mem_req ? addr_q[head_q] : '0;
  assign bus.mem_wdata = bus.mem_req ? data_q[head_q] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: everything read from it is qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.dataadr;
      data_q[tail_q] <= bus.writedata;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic          hit;
  logic [DW-1:0] hit_data;

  // Scan oldest to youngest so the last match, the youngest store, wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((i < 32'(count_q)) && (addr_q[idx][AW-1:2] == bus.dataadr[AW-1:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign bus.fwd_hit  = bus.memread && !bus.memwrite && hit;
  assign bus.fwd_data = bus.fwd_hit ? hit_data : '0;
  assign bus.stall    = bus.memwrite && full;
`else
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
  // Without forwarding a load waits for every older store to reach memory.
  assign bus.stall    = bus.memwrite ? full : (bus.memread && !bus.empty);
`endif
endmodule

// File: doc/mips_store_buffer.md
# mips_store_buffer

Posted-write buffer between the multicycle MIPS core's data port and data memory. Accepts core stores (`memwrite`, `dataadr`, `writedata`) in one cycle into a small FIFO and drains them to memory over a valid/ack handshake. Lets the core continue while memory is slow. Compile-time option forwards buffered store data to core loads.

## Interface
- `DEPTH`, 4: number of buffered stores; power of two, at least 2.
- `AW`, 32: byte address width.
- `DW`, 32: data width; word stores only.

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `memwrite`  in  1  core store request
- `memread`  in  1  core load request
- `dataadr`  in  AW  core byte address
- `writedata`  in  DW  core store data
- `stall`  out  1  core must hold its request this cycle
- `fwd_hit`  out  1  load address matches a buffered store
- `fwd_data`  out  DW  forwarded store data, valid when `fwd_hit`=1
- `empty`  out  1  no stores pending
- `mem_req`  out  1  head entry valid toward memory
- `mem_addr`  out  AW  head store address
- `mem_wdata`  out  DW  head store data
- `mem_ack`  in  1  memory accepts head entry this cycle

## Operation
- Circular FIFO: head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Push on a rising edge when `memwrite`=1 and `stall`=0. Stores {`dataadr`, `writedata`} at the tail, then tail+1.
- Pop on a rising edge when `mem_req`=1 and `mem_ack`=1. Advances the head.
- `mem_req` = (`count`!=0). `mem_addr` and `mem_wdata` are taken from the head entry and stay stable until popped.
- Push and pop in the same cycle: `count` unchanged, both pointers advance.
- Full (`count`=DEPTH):
  - `stall`=1 on `memwrite`, and the push is ignored even if a pop happens that cycle.
  - The core retries on the next cycle.
- Store address match uses the word address only, bits [AW-1:2]. Byte-offset bits are ignored.
- Load handling: see Configuration.
- `memwrite` and `memread` both high: treated as a store; `fwd_hit`=0.
- Reset (async, any time): pointers=0, count=0, all buffered stores discarded. Outputs `mem_req`=0, `stall`=0, `fwd_hit`=0, `empty`=1, `mem_addr`=0, `mem_wdata`=0, `fwd_data`=0. An in-flight `mem_req` drops immediately.

## Timing
- Store accepted on cycle N: `mem_req`=1 after edge N, earliest ack on cycle N+1. Minimum push-to-memory latency is 1 cycle.
- Drain throughput: one store per cycle while `mem_ack` is held at 1.
- `stall`, `fwd_hit` and `fwd_data` are combinational from the current request and state. There is no added cycle on a load hit.
- `empty` and `mem_req` are derived from registered `count` only, with no combinational path from `mem_ack`.
- A forwarding search in the same cycle as a pop of the matching head entry still hits; the data is taken from the pre-edge state.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - `memread` compares against all valid entries.
  - On one or more matches, `fwd_hit`=1 and `fwd_data` is the youngest matching entry; `stall`=0 for that load.
  - With no match, `stall`=0 and the load goes to memory. Memory must return data for non-buffered addresses only.
- `STORE_BUF_FWD_EN` undefined:
  - No comparators; `fwd_hit`=0 and `fwd_data`=0 always.
  - `memread` with `empty`=0 gives `stall`=1 until the buffer drains. This enforces memory ordering.

## Test plan
- Single store: `memwrite`, addr 0x0, data 7, `mem_ack`=1. Expect `mem_req`=1 on the next cycle with `mem_addr`=0, `mem_wdata`=7; after the ack, `empty`=1.
- Fill: `mem_ack`=0, 5 stores to 0x10..0x20 with DEPTH=4.
  - Expected: 4 accepted, then `stall`=1 on the fifth.
  - Release `mem_ack`: drains 0x10, 0x14, 0x18, 0x1C in order, then the fifth is accepted.
- Simultaneous: full buffer, `mem_ack`=1 and `memwrite` in the same cycle. Expect push rejected (`stall`=1), count becomes 3, retry succeeds next cycle.
- Forwarding (macro defined), ack held low:
  - Stores 0x40=0xAAAA then 0x40=0xBBBB; load at 0x42 gives `fwd_hit`=1, `fwd_data`=0xBBBB.
  - Load at 0x44 gives `fwd_hit`=0.
  - Macro undefined: load gives `stall`=1 until `empty`.
- Wrap-around: 10 store/ack pairs to 0x100+4i with data i. Expect memory order and data preserved across pointer wrap.
- Reset mid-drain: 3 stores pending, `reset_n` pulsed low mid-cycle. Expect `mem_req`=0 immediately and `empty`=1; a fresh store after reset drains correctly.
